// File: rtl/sal_ref_ctrl_pkg.sv
// Shared types and helpers for the per-bank auto-refresh request generator.
package sal_ref_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_OWED     = 2'd2,
    ST_URGENT   = 2'd3
  } ref_state_e;

  localparam int unsigned REFI_MIN = 2;

  // Intervals of 0 or 1 cannot be counted by a reload-at-zero counter.
  function automatic logic [31:0] eff_refi(input logic [31:0] t_refi);
    return (t_refi < REFI_MIN) ? REFI_MIN : t_refi;
  endfunction

endpackage

// File: rtl/sal_ref_ctrl_timer.sv
// Auto-reloading tREFI down-counter; tick marks the last cycle of each interval.
module sal_refi_timer
  import sal_ref_ctrl_pkg::*;
#(
  parameter int REFI_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [REFI_WIDTH-1:0] t_refi_i,
  output logic                  tick_o
);

  logic [REFI_WIDTH-1:0] cnt_q, cnt_d;
  logic [REFI_WIDTH-1:0] load_val;

  assign load_val = REFI_WIDTH'(eff_refi(32'(t_refi_i)) - 32'd1);
  assign tick_o   = en_i && (cnt_q == '0);

  // Reloading on every disabled cycle makes the first tick land eff_refi-1 cycles after enable.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) cnt_d = load_val;
    else                 cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sal_ref_ctrl.sv
// Refresh request generator: owed-refresh accounting, urgency and sticky overflow.
module sal_ref_ctrl
  import sal_ref_ctrl_pkg::*;
#(
  parameter int REFI_WIDTH = 16,
  parameter int PEND_WIDTH = 4,
  parameter int MAX_PEND   = 8,
  parameter int URGENT_TH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [REFI_WIDTH-1:0] t_refi_i,
  output logic                  ref_req_o,
  input  logic                  ref_gnt_i,
  output logic                  urgent_o,
  output logic [PEND_WIDTH-1:0] pend_cnt_o,
  output logic                  overflow_o,
  output ref_state_e            state_o
);

  logic                  tick;
  logic                  vgnt;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  en_q;

  sal_refi_timer #(.REFI_WIDTH(REFI_WIDTH)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .t_refi_i (t_refi_i),
    .tick_o   (tick)
  );

  // A grant with nothing owed is ignored so pend never underflows.
  assign vgnt = ref_gnt_i && (pend_q != '0);

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (!en_i) begin
      pend_d = '0;
    end else if (tick && !vgnt) begin
      if (pend_q == PEND_WIDTH'(MAX_PEND)) ovf_d  = 1'b1;
      else                                 pend_d = pend_q + 1'b1;
    end else if (!tick && vgnt) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      en_q   <= en_i;
    end
  end

  assign ref_req_o  = (pend_q != '0);
  assign urgent_o   = (pend_q >= PEND_WIDTH'(URGENT_TH));
  assign pend_cnt_o = pend_q;
  assign overflow_o = ovf_q;

  // Operating state is a pure decode of registered en and pend.
  always_comb begin
    state_o = ST_COUNTING;
    if (!en_q)         state_o = ST_IDLE;
    else if (urgent_o) state_o = ST_URGENT;
    else if (ref_req_o) state_o = ST_OWED;
  end

endmodule
